// File: rtl/dsi_pixel_fifo.sv
// dsi_pixel_fifo: buffers 48-bit double pixels from the framebuffer reader
// and streams them out one 24-bit pixel per cycle with line/frame tags.
//
// Ports:
//   clk_sys_i, rst_i          clock, async active-high reset
//   enable_i                  streaming enable
//   h_active_i, v_active_i    frame geometry (sampled in FLUSH)
//   frame_start_i             frame request from timing generator
//   pix_i, pix_wr_i           double-pixel write side
//   pix_almost_full_o         back-pressure to framebuffer
//   pix_next_frame_o          fetch-start pulse (FLUSH cycle)
//   pix_o, pix_valid_o,
//   pix_ready_i               pixel stream
//   pix_sof_o, pix_sol_o,
//   pix_eol_o                 framing tags, qualified by pix_valid_o
//   clear_flags_i             clears sticky flags
//   overflow_o, underrun_o    sticky error flags
module dsi_pixel_fifo #(
  parameter int g_depth_log2   = 6,
  parameter int g_af_threshold = 56
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [11:0] h_active_i,
  input  logic [11:0] v_active_i,
  input  logic        frame_start_i,
  input  logic [47:0] pix_i,
  input  logic        pix_wr_i,
  output logic        pix_almost_full_o,
  output logic        pix_next_frame_o,
  output logic [23:0] pix_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic        pix_sof_o,
  output logic        pix_sol_o,
  output logic        pix_eol_o,
  input  logic        clear_flags_i,
  output logic        overflow_o,
  output logic        underrun_o
);

  localparam int DEPTH = 1 << g_depth_log2;
  localparam int CW    = g_depth_log2 + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(g_af_threshold);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [47:0]             mem [DEPTH];
  logic [g_depth_log2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [47:0]             hold_q;
  logic                    hold_half_q;
  logic                    hold_vld_q;
  logic [11:0]             x_q, y_q;
  logic [11:0]             h_q, v_q;
  logic                    started_q;
  logic                    overflow_q, underrun_q;

  logic active, full, empty, hs;
  logic last_x, last_px;
  logic flush_all;
  logic wr_en, rd_en;
  logic ovf_set, und_set;

  assign active  = (state_q == ST_ACTIVE);
  assign full    = (count_q == FULL_LVL);
  assign empty   = (count_q == '0);
  assign hs      = pix_valid_o && pix_ready_i;
  assign last_x  = (x_q == h_q - 12'd1);
  assign last_px = last_x && (y_q == v_q - 12'd1);

  // flush_all marks entry into FLUSH or an enable drop, so the FIFO and
  // holding register are already empty during the FLUSH cycle itself.
  always_comb begin
    state_d   = state_q;
    flush_all = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_i && enable_i) begin
          state_d   = ST_FLUSH;
          flush_all = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = enable_i ? ST_ACTIVE : ST_IDLE;
      end
      ST_ACTIVE: begin
        if (!enable_i) begin
          state_d   = ST_IDLE;
          flush_all = 1'b1;
        end else if (frame_start_i) begin
          state_d   = ST_FLUSH;
          flush_all = 1'b1;
        end else if (hs && last_px) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en = pix_wr_i && !full &&
                 (state_q != ST_FLUSH) && !flush_all;
  // Reload when the holding register is empty or its lower half
  // leaves this cycle: keeps a bubble-free 1 pixel/cycle stream.
  assign rd_en = active && !empty && !flush_all &&
                 (!hold_vld_q || (hs && hold_half_q));

  assign ovf_set = pix_wr_i && full && (state_q != ST_FLUSH);
  assign und_set = active &&
                   ((pix_ready_i && !pix_valid_o && started_q) ||
                    (frame_start_i && enable_i));

  assign pix_almost_full_o = (count_q >= AF_LVL);
  assign pix_next_frame_o  = (state_q == ST_FLUSH);
  assign pix_valid_o       = active && hold_vld_q;
  assign pix_o = !pix_valid_o ? 24'd0 :
                 hold_half_q  ? hold_q[23:0] : hold_q[47:24];
  assign pix_sol_o  = pix_valid_o && (x_q == 12'd0);
  assign pix_eol_o  = pix_valid_o && last_x;
  assign pix_sof_o  = pix_sol_o && (y_q == 12'd0);
  assign overflow_o = overflow_q;
  assign underrun_o = underrun_q;

  always_ff @(posedge clk_sys_i) begin
    if (wr_en) mem[wr_ptr_q] <= pix_i;
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      hold_half_q <= 1'b0;
      hold_vld_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      h_q         <= '0;
      v_q         <= '0;
      started_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (flush_all) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q
                 + {{g_depth_log2{1'b0}}, wr_en}
                 - {{g_depth_log2{1'b0}}, rd_en};
      end

      if (flush_all) begin
        hold_vld_q  <= 1'b0;
        hold_half_q <= 1'b0;
      end else if (rd_en) begin
        hold_q      <= mem[rd_ptr_q];
        hold_vld_q  <= 1'b1;
        hold_half_q <= 1'b0;
      end else if (hs) begin
        if (hold_half_q) hold_vld_q <= 1'b0;
        else hold_half_q <= 1'b1;
      end

      if (flush_all) begin
        x_q       <= '0;
        y_q       <= '0;
        started_q <= 1'b0;
      end else if (hs) begin
        started_q <= 1'b1;
        if (last_x) begin
          x_q <= '0;
          y_q <= y_q + 12'd1;
        end else begin
          x_q <= x_q + 12'd1;
        end
      end

      if (state_q == ST_FLUSH) begin
        h_q <= h_active_i;
        v_q <= v_active_i;
      end

      if (ovf_set)            overflow_q <= 1'b1;
      else if (clear_flags_i) overflow_q <= 1'b0;

      if (und_set)            underrun_q <= 1'b1;
      else if (clear_flags_i) underrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsi_pixel_fifo.sv
// tb_dsi_pixel_fifo: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the pixel FIFO.
module tb_dsi_pixel_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] hact, vact;
  logic        fs;
  logic [47:0] pixw;
  logic        wr;
  logic        af, nf;
  logic [23:0] pix;
  logic        pv;
  logic        rdy;
  logic        sof, sol, eol;
  logic        clr;
  logic        ovf, und;

  logic [31:0] outs;
  assign outs = {af, nf, pv, sof, sol, eol, ovf, und, pix};

  dsi_pixel_fifo #(
    .g_depth_log2  (6),
    .g_af_threshold(56)
  ) dut (
    .clk_sys_i        (clk),
    .rst_i            (rst),
    .enable_i         (en),
    .h_active_i       (hact),
    .v_active_i       (vact),
    .frame_start_i    (fs),
    .pix_i            (pixw),
    .pix_wr_i         (wr),
    .pix_almost_full_o(af),
    .pix_next_frame_o (nf),
    .pix_o            (pix),
    .pix_valid_o      (pv),
    .pix_ready_i      (rdy),
    .pix_sof_o        (sof),
    .pix_sol_o        (sol),
    .pix_eol_o        (eol),
    .clear_flags_i    (clr),
    .overflow_o       (ovf),
    .underrun_o       (und)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 flush, 2 active; word queue, pixel queue
  // for the output stage, and a running pixel index within the frame.
  int          mst;
  logic [47:0] mq[$];
  logic [23:0] mh[$];
  int          mn, mhs, mvs;
  bit          mstarted, movf, mund;

  always @(negedge clk) begin : model
    bit v, hs, us, os, fl;
    int nst, pre, x, y;
    logic [47:0] w;
    logic [31:0] expv;
    if (rst) begin
      mst = 0; mq.delete(); mh.delete(); mn = 0;
      mstarted = 0; movf = 0; mund = 0; mhs = 0; mvs = 0;
      chk("reset_outs", {32'd0, outs}, 64'd0);
    end else begin
      v = (mst == 2) && (mh.size() > 0);
      x = v ? mn % mhs : 0;
      y = v ? mn / mhs : 0;
      expv = {mq.size() >= 56, mst == 1, v, v && x == 0 && y == 0,
              v && x == 0, v && x == mhs - 1, movf, mund,
              v ? mh[0] : 24'd0};
      chk("cycle", {32'd0, outs}, {32'd0, expv});

      hs = v && rdy;
      us = (mst == 2) && ((rdy && !v && mstarted) || (fs && en));
      os = wr && (mq.size() == 64) && (mst != 1);
      if (us) mund = 1; else if (clr) mund = 0;
      if (os) movf = 1; else if (clr) movf = 0;
      if (mst == 1) begin mhs = hact; mvs = vact; end

      nst = mst; fl = 0; pre = mq.size();
      case (mst)
        0: begin
          if (fs && en) begin nst = 1; fl = 1; end
          else if (wr && pre < 64) mq.push_back(pixw);
        end
        1: nst = en ? 2 : 0;
        default: begin
          if (!en) begin nst = 0; fl = 1; end
          else if (fs) begin nst = 1; fl = 1; end
          else begin
            if (hs) begin
              void'(mh.pop_front());
              mstarted = 1;
              if (mn == mhs * mvs - 1) nst = 0;
              mn++;
            end
            if (mh.size() == 0 && pre > 0) begin
              w = mq.pop_front();
              mh.push_back(w[47:24]);
              mh.push_back(w[23:0]);
            end
            if (wr && pre < 64) mq.push_back(pixw);
          end
        end
      endcase
      if (fl) begin
        mq.delete(); mh.delete(); mn = 0; mstarted = 0;
      end
      mst = nst;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input int h, input int v);
    hact = 12'(h); vact = 12'(v); en = 1; fs = 1;
    step();
    fs = 0;
    @(negedge clk);
    chk("next_frame_pulse", nf, 1'b1);
    step();
  endtask

  // 4x2 frame, 4 words; optional ready toggling.
  task automatic frame_4x2(input bit toggle, input string tag);
    int got, firstc, lastc;
    bit stall;
    logic [23:0] prevp;
    got = 0; firstc = -1; lastc = -1; stall = 0; prevp = '0;
    start_frame(4, 2);
    for (int c = 0; c < 60 && got < 8; c++) begin
      wr   = (c < 4);
      pixw = {24'hA00000 + 24'(2 * c), 24'hA00000 + 24'(2 * c + 1)};
      rdy  = toggle ? (c % 2 == 1) : 1'b1;
      @(negedge clk);
      if (stall) chk({tag, "_held"}, {pv, pix}, {1'b1, prevp});
      if (pv && rdy) begin
        chk({tag, "_pix"}, pix, 24'hA00000 + 24'(got));
        chk({tag, "_tags"}, {sof, sol, eol},
            {got == 0, got % 4 == 0, got % 4 == 3});
        if (firstc < 0) firstc = c;
        lastc = c;
        got++;
      end
      stall = pv && !rdy;
      prevp = pix;
      step();
    end
    wr = 0;
    chk({tag, "_count"}, got, 8);
    if (!toggle) chk({tag, "_no_gap"}, lastc - firstc, 7);
    @(negedge clk);
    chk({tag, "_idle_after"}, {pv, und}, 2'b00);
    step();
  endtask

  initial begin : stim
    int got;
    rst = 1; en = 0; hact = 12'd4; vact = 12'd2; fs = 0;
    pixw = '0; wr = 0; rdy = 0; clr = 0;
    @(negedge clk);
    chk("reset_state", outs, 32'd0);
    step(); step();
    rst = 0;
    step();

    // normal frame, then consumer stall
    frame_4x2(1'b0, "normal");
    frame_4x2(1'b1, "stall");

    // back-pressure and overflow in IDLE (no draining)
    en = 1; rdy = 0;
    for (int i = 0; i <= 66; i++) begin
      wr   = (i < 65);
      pixw = {$urandom, $urandom};
      @(negedge clk);
      chk("almost_full", af, i >= 56);
      chk("overflow", ovf, i >= 65);
      step();
    end
    wr = 0; clr = 1;
    step();
    clr = 0;
    @(negedge clk);
    chk("overflow_clear", {ovf, af}, 2'b01);
    step();

    // underrun: one word for an 8-pixel line
    start_frame(8, 1);
    rdy = 1;
    for (int c = 0; c < 20; c++) begin
      wr   = (c == 0);
      pixw = 48'h111111_222222;
      @(negedge clk);
      if (und) break;
      step();
    end
    wr = 0;
    chk("underrun_set", und, 1'b1);
    step();
    clr = 1;
    step();
    clr = 0;
    @(negedge clk);
    chk("underrun_clear_blocked", und, 1'b1);
    step();
    rdy = 0; clr = 1;
    step();
    clr = 0;
    @(negedge clk);
    chk("underrun_clear", und, 1'b0);
    step();
    en = 0;
    step();

    // resync after 3 pixels
    start_frame(4, 2);
    rdy = 1; got = 0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      wr   = (c < 4);
      pixw = {24'hA00000 + 24'(2 * c), 24'hA00000 + 24'(2 * c + 1)};
      @(negedge clk);
      if (pv && rdy) got++;
      step();
    end
    wr = 0;
    chk("resync_pre_count", got, 3);
    chk("resync_pre_und", und, 1'b0);
    fs = 1;
    step();
    fs = 0;
    @(negedge clk);
    chk("resync_flush", {nf, und, af, pv}, 4'b1100);
    step();
    got = 0;
    for (int c = 0; c < 20; c++) begin
      wr   = (c < 2);
      pixw = {24'hB00000 + 24'(2 * c), 24'hB00000 + 24'(2 * c + 1)};
      @(negedge clk);
      if (pv) begin got = 1; break; end
      step();
    end
    chk("resync_first", {got[0], sof, pix}, {1'b1, 1'b1, 24'hB00000});
    step();
    wr = 0; en = 0;
    step();

    // async reset mid-frame
    start_frame(4, 2);
    rdy = 1; got = 0;
    for (int c = 0; c < 20; c++) begin
      wr   = (c < 2);
      pixw = 48'hCCCCCC_DDDDDD;
      @(negedge clk);
      if (pv) begin got = 1; break; end
      step();
    end
    chk("pre_reset_valid", got, 1);
    @(posedge clk);
    #3 rst = 1;
    #1 chk("async_reset", outs, 32'd0);
    wr = 0;
    @(posedge clk);
    #1 rst = 0;
    step();

    // enable drop with a nearly full FIFO
    start_frame(4, 2);
    rdy = 0;
    for (int c = 0; c < 60; c++) begin
      wr   = 1;
      pixw = {$urandom, $urandom};
      step();
    end
    wr = 0;
    @(negedge clk);
    chk("pre_drop_af", af, 1'b1);
    step();
    en = 0;
    step();
    @(negedge clk);
    chk("enable_drop", {af, pv, nf}, 3'b000);
    step();

    // randomized traffic
    clr = 1;
    step();
    clr = 0;
    for (int c = 0; c < 4000; c++) begin
      en   = ($urandom_range(0, 199) != 0);
      fs   = ($urandom_range(0, 59) == 0);
      wr   = ($urandom_range(0, 2) != 0);
      pixw = {$urandom, $urandom};
      rdy  = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 39) == 0);
      if (fs) begin
        hact = 12'(2 * $urandom_range(1, 4));
        vact = 12'($urandom_range(1, 3));
      end
      step();
    end
    en = 0; fs = 0; wr = 0; clr = 0; rdy = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
